yarp_decode_q: RTL and testbench
================================

// Module: yarp_decode_q
// PURPOSE
//  Buffered, parametrised decode stage between fetch and execute. Accepts raw instructions+PC over
//  valid/ready, queues them in a DEPTH-entry FIFO, decodes the head and presents registered fields
//  (regs, opcode, functs, one-hot type, XLEN-wide immediate, illegal flag) over a second valid/ready.
//  Adds back-pressure, flush, XLEN generalisation and illegal-opcode detection.
// PARAMETERS
//  XLEN   32  datapath width (32 or 64); immediates and PC sign/zero-extended to XLEN
//  DEPTH  2   instruction FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1        clock
//  reset           in   1        asynchronous, active-high reset
//  flush_i         in   1        synchronous flush of all buffered/decoded instructions
//  fetch_valid_i   in   1        fetch beat valid
//  fetch_ready_o   out  1        FIFO can accept a beat
//  fetch_instr_i   in   32       raw instruction
//  fetch_pc_i      in   XLEN     instruction PC
//  dec_valid_o     out  1        decoded output register valid
//  dec_ready_i     in   1        consumer accepts decoded beat
//  dec_pc_o        out  XLEN     PC of decoded instruction
//  rs1_o/rs2_o/rd_o out 5 each   register indices [19:15]/[24:20]/[11:7]
//  op_o            out  7        opcode [6:0]
//  funct3_o        out  3        [14:12]
//  funct7_o        out  7        [31:25]
//  instr_type_o    out  6        one-hot {j,u,b,s,i,r} (bit0 = r)
//  instr_imm_o     out  XLEN     sign-extended immediate
//  illegal_o       out  1        unrecognised opcode
//  occupancy_o     out  $clog2(DEPTH+1)  FIFO entries in use (output register excluded)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO pointers/count 0, dec_valid_o=0; fetch_ready_o=1 one cycle after release.
//  - fetch_ready_o = (occupancy_o != DEPTH); registered-state only, no comb path from dec_ready_i.
//  - Push when fetch_valid_i&&fetch_ready_o&&!flush_i; pop to output reg when out reg empty or
//    (dec_valid_o&&dec_ready_i). Push and pop same cycle: count unchanged.
//  - Bypass: FIFO empty and out reg free -> accepted beat loads output reg directly; latency 1 cycle
//    (accept edge N, dec_valid_o high after N). Otherwise strict FIFO order.
//  - Output reg holds all fields stable while dec_valid_o && !dec_ready_i.
//  - Pointers wrap modulo DEPTH; count 0..DEPTH; no overflow/underflow under legal handshakes.
//  - Type decode from yarp_pkg opcodes: R_TYPE->r; I_TYPE_0/1/2->i; S_TYPE->s; B_TYPE->b;
//    U_TYPE_0/1->u; J_TYPE->j. Anything else (incl. instr[1:0]!=2'b11): type=0, illegal_o=1, imm=0.
//  - Immediates: I {[31:20]}, S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0},
//    U {[31:12],12'b0}, J {[31],[19:12],[20],[30:21],0}; all sign-extended from bit 31 to XLEN.
//    R-type imm = 0.
//  - flush_i: next edge clears FIFO count/pointers and dec_valid_o; same-cycle fetch beat dropped;
//    flush wins over push and pop. Data fields need not clear.
//  - Reset mid-operation discards everything; no partial beat survives.
// STRUCTURE
//  - yarp_pkg: reuse opcode constants; add instr_type_e/one-hot bit indices and a
//    dec_fields_t packed struct (rs1,rs2,rd,op,funct3,funct7,type,imm,illegal).
//  - Sub-module yarp_decode_core #(XLEN): pure combinational instr->dec_fields_t.
//  - Top: FIFO (storage, wr/rd ptr, count), one output register of {pc, dec_fields_t}, control.
// TESTING
//  - ADDI x1,x0,-1 0xFFF00093, XLEN=32 -> rd=1, type=6'b000010, imm=0xFFFFFFFF, illegal=0, 1-cycle latency.
//  - XLEN=64 LUI 0x800000B7 -> type=6'b010000, imm=0xFFFFFFFF80000000; JAL 0x8000006F ->
//    imm=0xFFFFFFFFFFF00000.
//  - 0x00000000 and 0x0000007F -> illegal_o=1, instr_type_o=0, instr_imm_o=0.
//  - DEPTH=2, dec_ready_i=0, push A,B,C,D -> output A, occupancy 2, fetch_ready_o=0 for D;
//    release ready -> A,B,C,D in order, no loss/duplication.
//  - Full FIFO, flush_i with fetch_valid_i=1 -> next cycle dec_valid_o=0, occupancy_o=0, beat dropped.
//  - reset asserted mid-stream (asynchronously, between edges) -> outputs 0 immediately; resume from clean state.

Source files
------------

// File: rtl/yarp_decode_q_pkg.sv
// Shared decode definitions: RV32 base opcodes, one-hot type bit positions and
// the decoded-field bundle passed from the decode core to the output register.
package yarp_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] R_TYPE   = 7'h33;
  localparam logic [6:0] I_TYPE_0 = 7'h03;
  localparam logic [6:0] I_TYPE_1 = 7'h13;
  localparam logic [6:0] I_TYPE_2 = 7'h67;
  localparam logic [6:0] S_TYPE   = 7'h23;
  localparam logic [6:0] B_TYPE   = 7'h63;
  localparam logic [6:0] U_TYPE_0 = 7'h37;
  localparam logic [6:0] U_TYPE_1 = 7'h17;
  localparam logic [6:0] J_TYPE   = 7'h6F;

  // Bit positions inside the one-hot instr_type vector.
  typedef enum logic [2:0] {
    IT_R = 3'd0,
    IT_I = 3'd1,
    IT_S = 3'd2,
    IT_B = 3'd3,
    IT_U = 3'd4,
    IT_J = 3'd5
  } instr_type_e;

  typedef struct packed {
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [5:0]          itype;
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
  } dec_fields_t;

endpackage

// File: rtl/yarp_decode_q_if.sv
// Fetch-side and consumer-side handshakes of the buffered decode stage.
// slave is the decode stage's view, master is the surrounding pipeline's.
interface yarp_decode_q_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush_i;
  logic              fetch_valid_i;
  logic              fetch_ready_o;
  logic [31:0]       fetch_instr_i;
  logic [XLEN-1:0]   fetch_pc_i;
  logic              dec_valid_o;
  logic              dec_ready_i;
  logic [XLEN-1:0]   dec_pc_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [4:0]        rd_o;
  logic [6:0]        op_o;
  logic [2:0]        funct3_o;
  logic [6:0]        funct7_o;
  logic [5:0]        instr_type_o;
  logic [XLEN-1:0]   instr_imm_o;
  logic              illegal_o;
  logic [CNT_W-1:0]  occupancy_o;

  modport master (
    output flush_i, fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
    input  fetch_ready_o, dec_valid_o, dec_pc_o, rs1_o, rs2_o, rd_o, op_o,
           funct3_o, funct7_o, instr_type_o, instr_imm_o, illegal_o, occupancy_o
  );

  modport slave (
    input  flush_i, fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
    output fetch_ready_o, dec_valid_o, dec_pc_o, rs1_o, rs2_o, rd_o, op_o,
           funct3_o, funct7_o, instr_type_o, instr_imm_o, illegal_o, occupancy_o
  );

endinterface

// File: rtl/yarp_decode_q_core.sv
// Purely combinational RV32 field extraction and immediate generation.
// Immediates are sign-extended from bit 31 and trimmed to XLEN.
module yarp_decode_core
  import yarp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] i_instr,
  output dec_fields_t o_fields
);

  localparam logic [XLEN_MAX-1:0] IMM_MASK = {XLEN_MAX{1'b1}} >> (XLEN_MAX - XLEN);

  logic [31:0] w_imm32;

  always_comb begin
    o_fields        = '0;
    w_imm32         = '0;
    o_fields.rs1    = i_instr[19:15];
    o_fields.rs2    = i_instr[24:20];
    o_fields.rd     = i_instr[11:7];
    o_fields.op     = i_instr[6:0];
    o_fields.funct3 = i_instr[14:12];
    o_fields.funct7 = i_instr[31:25];
    // Opcodes with instr[1:0] != 2'b11 never match and fall through as illegal.
    case (i_instr[6:0])
      R_TYPE: o_fields.itype[IT_R] = 1'b1;
      I_TYPE_0, I_TYPE_1, I_TYPE_2: begin
        o_fields.itype[IT_I] = 1'b1;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      S_TYPE: begin
        o_fields.itype[IT_S] = 1'b1;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      B_TYPE: begin
        o_fields.itype[IT_B] = 1'b1;
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                   i_instr[11:8], 1'b0};
      end
      U_TYPE_0, U_TYPE_1: begin
        o_fields.itype[IT_U] = 1'b1;
        w_imm32 = {i_instr[31:12], 12'b0};
      end
      J_TYPE: begin
        o_fields.itype[IT_J] = 1'b1;
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                   i_instr[30:21], 1'b0};
      end
      default: o_fields.illegal = 1'b1;
    endcase
    o_fields.imm = {{(XLEN_MAX-32){w_imm32[31]}}, w_imm32} & IMM_MASK;
  end

endmodule

// File: rtl/yarp_decode_q.sv
// Buffered decode stage: DEPTH-entry instruction FIFO feeding one registered
// decoded-output slot, with empty-FIFO bypass and synchronous flush.
module yarp_decode_q
  import yarp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  yarp_decode_q_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      r_mem_instr [DEPTH];
  logic [XLEN-1:0]  r_mem_pc    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_fetch_ready;
  logic             r_dec_valid;
  logic [XLEN-1:0]  r_dec_pc;
  dec_fields_t      r_fields;

  logic             w_out_free;
  logic             w_push;
  logic             w_bypass;
  logic             w_fifo_push;
  logic             w_pop;
  logic             w_load;
  logic [31:0]      w_src_instr;
  logic [XLEN-1:0]  w_src_pc;
  logic [CNT_W-1:0] w_count_nxt;
  dec_fields_t      w_fields;

  assign w_out_free  = !r_dec_valid || bus.dec_ready_i;
  assign w_push      = bus.fetch_valid_i && r_fetch_ready && !bus.flush_i;
  assign w_bypass    = w_push && (r_count == '0) && w_out_free;
  assign w_fifo_push = w_push && !w_bypass;
  assign w_pop       = (r_count != '0) && w_out_free && !bus.flush_i;
  assign w_load      = w_bypass || w_pop;

  // With an empty FIFO the only possible source is the incoming beat.
  assign w_src_instr = (r_count == '0) ? bus.fetch_instr_i : r_mem_instr[r_rd_ptr];
  assign w_src_pc    = (r_count == '0) ? bus.fetch_pc_i    : r_mem_pc[r_rd_ptr];

  yarp_decode_core #(.XLEN(XLEN)) u_core (
    .i_instr  (w_src_instr),
    .o_fields (w_fields)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (bus.flush_i)
      w_count_nxt = '0;
    else if (w_fifo_push && !w_pop)
      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_fifo_push && w_pop)
      w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_fetch_ready <= 1'b0;
      r_dec_valid   <= 1'b0;
      r_dec_pc      <= '0;
      r_fields      <= '0;
    end else begin
      r_count       <= w_count_nxt;
      r_fetch_ready <= (w_count_nxt != CNT_W'(DEPTH));
      if (bus.flush_i) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_dec_valid <= 1'b0;
      end else begin
        if (w_fifo_push)
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_load)
          r_dec_valid <= 1'b1;
        else if (bus.dec_ready_i)
          r_dec_valid <= 1'b0;
      end
      if (w_load) begin
        r_dec_pc <= w_src_pc;
        r_fields <= w_fields;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fifo_push) begin
      r_mem_instr[r_wr_ptr] <= bus.fetch_instr_i;
      r_mem_pc[r_wr_ptr]    <= bus.fetch_pc_i;
    end
  end

  if (XLEN < XLEN_MAX) begin : g_imm_pad
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^r_fields.imm[XLEN_MAX-1:XLEN];
  end

  assign bus.fetch_ready_o = r_fetch_ready;
  assign bus.occupancy_o   = r_count;
  assign bus.dec_valid_o   = r_dec_valid;
  assign bus.dec_pc_o      = r_dec_pc;
  assign bus.rs1_o         = r_fields.rs1;
  assign bus.rs2_o         = r_fields.rs2;
  assign bus.rd_o          = r_fields.rd;
  assign bus.op_o          = r_fields.op;
  assign bus.funct3_o      = r_fields.funct3;
  assign bus.funct7_o      = r_fields.funct7;
  assign bus.instr_type_o  = r_fields.itype;
  assign bus.instr_imm_o   = r_fields.imm[XLEN-1:0];
  assign bus.illegal_o     = r_fields.illegal;

endmodule

// File: tb/tb_yarp_decode_q.sv
// Scoreboard bench for yarp_decode_q: an XLEN=32 instance for ordering, back-pressure,
// flush and reset, plus an XLEN=64 instance for wide sign extension.
module tb_yarp_decode_q;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  yarp_decode_q_if #(.XLEN(32), .DEPTH(2)) bus32 ();
  yarp_decode_q_if #(.XLEN(64), .DEPTH(2)) bus64 ();

  yarp_decode_q #(.XLEN(32), .DEPTH(2)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  yarp_decode_q #(.XLEN(64), .DEPTH(2)) u_dut64 (.clk(clk), .reset(reset), .bus(bus64));

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [5:0]  ty;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pc32  = 32'h0000_1000;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every beat the consumer takes must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus32.dec_valid_o && bus32.dec_ready_i) begin
      if (sb_q.size() == 0) begin
        check_val("sb_output_without_stimulus", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_pc",      64'(bus32.dec_pc_o),     mon_e.pc);
        check_val("sb_type",    64'(bus32.instr_type_o), 64'(mon_e.ty));
        check_val("sb_imm",     64'(bus32.instr_imm_o),  mon_e.imm);
        check_val("sb_illegal", 64'(bus32.illegal_o),    64'(mon_e.ill));
        check_val("sb_rd",      64'(bus32.rd_o),         64'(mon_e.instr[11:7]));
        check_val("sb_rs1",     64'(bus32.rs1_o),        64'(mon_e.instr[19:15]));
        check_val("sb_rs2",     64'(bus32.rs2_o),        64'(mon_e.instr[24:20]));
        check_val("sb_op",      64'(bus32.op_o),         64'(mon_e.instr[6:0]));
        check_val("sb_funct3",  64'(bus32.funct3_o),     64'(mon_e.instr[14:12]));
        check_val("sb_funct7",  64'(bus32.funct7_o),     64'(mon_e.instr[31:25]));
      end
    end
  end

  task automatic send32(input logic [31:0] ins, input logic [5:0] ty,
                        input logic [63:0] im, input logic il);
    exp_t e;
    bit   done = 1'b0;
    bus32.fetch_valid_i = 1'b1;
    bus32.fetch_instr_i = ins;
    bus32.fetch_pc_i    = pc32;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus32.fetch_ready_o) begin
        e.pc = 64'(pc32); e.instr = ins; e.ty = ty; e.imm = im; e.ill = il;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check_val("send32_timeout", 64'(done), 64'd1);
    bus32.fetch_valid_i = 1'b0;
    pc32 = pc32 + 32'd4;
  endtask

  task automatic send64(input logic [31:0] ins, input logic [63:0] pc,
                        input logic [5:0] ty, input logic [63:0] im, input logic il);
    bus64.fetch_valid_i = 1'b1;
    bus64.fetch_instr_i = ins;
    bus64.fetch_pc_i    = pc;
    @(negedge clk);
    check_val("x64_fetch_ready", 64'(bus64.fetch_ready_o), 64'd1);
    @(posedge clk); #1;
    bus64.fetch_valid_i = 1'b0;
    check_val("x64_valid",   64'(bus64.dec_valid_o),  64'd1);
    check_val("x64_pc",      bus64.dec_pc_o,          pc);
    check_val("x64_type",    64'(bus64.instr_type_o), 64'(ty));
    check_val("x64_imm",     bus64.instr_imm_o,       im);
    check_val("x64_illegal", 64'(bus64.illegal_o),    64'(il));
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(posedge clk);
    #1;
    check_val("sb_drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    bus32.flush_i = 1'b0; bus32.fetch_valid_i = 1'b0; bus32.fetch_instr_i = '0;
    bus32.fetch_pc_i = '0; bus32.dec_ready_i = 1'b0;
    bus64.flush_i = 1'b0; bus64.fetch_valid_i = 1'b0; bus64.fetch_instr_i = '0;
    bus64.fetch_pc_i = '0; bus64.dec_ready_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_dec_valid", 64'(bus32.dec_valid_o),   64'd0);
    check_val("rst_ready",     64'(bus32.fetch_ready_o), 64'd0);
    check_val("rst_occupancy", 64'(bus32.occupancy_o),   64'd0);
    check_val("rst_imm",       64'(bus32.instr_imm_o),   64'd0);
    check_val("rst_type",      64'(bus32.instr_type_o),  64'd0);
    check_val("rst_pc",        64'(bus32.dec_pc_o),      64'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rel_ready_before_edge", 64'(bus32.fetch_ready_o), 64'd0);
    @(posedge clk); #1;
    check_val("rel_ready_after_edge", 64'(bus32.fetch_ready_o), 64'd1);

    // Wide datapath: sign extension of U/J/I immediates and illegal handling.
    bus64.dec_ready_i = 1'b1;
    send64(32'h800000B7, 64'hFFFF_FFFF_0000_0100, 6'b010000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send64(32'h8000006F, 64'h8000_0000_0000_0104, 6'b100000, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    send64(32'hFFF00093, 64'h0000_0000_0000_0108, 6'b000010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send64(32'h0000007F, 64'h0000_0000_0000_010C, 6'b000000, 64'h0,                   1'b1);

    // ADDI x1,x0,-1 with a one-cycle accept-to-valid latency.
    bus32.dec_ready_i = 1'b1;
    send32(32'hFFF00093, 6'b000010, 64'hFFFF_FFFF, 1'b0);
    check_val("bypass_latency", 64'(bus32.dec_valid_o), 64'd1);
    check_val("bypass_rd",      64'(bus32.rd_o),        64'd1);

    send32(32'h00000000, 6'b000000, 64'h0,         1'b1);
    send32(32'h0000007F, 6'b000000, 64'h0,         1'b1);
    send32(32'h00000031, 6'b000000, 64'h0,         1'b1);
    send32(32'h800000B7, 6'b010000, 64'h8000_0000, 1'b0);
    send32(32'h8000006F, 6'b100000, 64'hFFF0_0000, 1'b0);
    send32(32'hFE20AE23, 6'b000100, 64'hFFFF_FFFC, 1'b0);
    send32(32'hFE000CE3, 6'b001000, 64'hFFFF_FFF8, 1'b0);
    send32(32'h002081B3, 6'b000001, 64'h0,         1'b0);
    send32(32'h12345297, 6'b010000, 64'h1234_5000, 1'b0);
    send32(32'h00812303, 6'b000010, 64'h8,         1'b0);
    send32(32'h00008067, 6'b000010, 64'h0,         1'b0);
    drain();

    // Back-pressure: A in the output slot, B and C fill the FIFO, D must stall.
    bus32.dec_ready_i = 1'b0;
    send32(32'h00100093, 6'b000010, 64'h1, 1'b0);
    send32(32'h00200113, 6'b000010, 64'h2, 1'b0);
    send32(32'h00300193, 6'b000010, 64'h3, 1'b0);
    bus32.fetch_valid_i = 1'b1;
    bus32.fetch_instr_i = 32'h00400213;
    bus32.fetch_pc_i    = pc32;
    @(negedge clk);
    check_val("full_ready",     64'(bus32.fetch_ready_o), 64'd0);
    check_val("full_occupancy", 64'(bus32.occupancy_o),   64'd2);
    check_val("full_head_pc",   64'(bus32.dec_pc_o),      sb_q[0].pc);
    @(posedge clk); #1;
    check_val("held_head_pc",   64'(bus32.dec_pc_o),      sb_q[0].pc);
    bus32.dec_ready_i = 1'b1;
    send32(32'h00400213, 6'b000010, 64'h4, 1'b0);
    drain();

    // Flush with a full FIFO, then with a partly filled one where the beat could be accepted.
    for (int k = 3; k >= 2; k--) begin
      bus32.dec_ready_i = 1'b0;
      for (int j = 0; j < k; j++) send32(32'h00500293, 6'b000010, 64'h5, 1'b0);
      bus32.fetch_valid_i = 1'b1;
      bus32.fetch_instr_i = 32'h00600313;
      bus32.fetch_pc_i    = pc32;
      bus32.flush_i       = 1'b1;
      @(posedge clk); #1;
      bus32.flush_i       = 1'b0;
      bus32.fetch_valid_i = 1'b0;
      sb_q.delete();
      check_val("flush_dec_valid", 64'(bus32.dec_valid_o), 64'd0);
      check_val("flush_occupancy", 64'(bus32.occupancy_o), 64'd0);
      check_val("flush_ready",     64'(bus32.fetch_ready_o), 64'd1);
      bus32.dec_ready_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_val("flush_no_ghost", 64'(bus32.dec_valid_o), 64'd0);
    end
    send32(32'h00700393, 6'b000010, 64'h7, 1'b0);
    drain();

    // Asynchronous reset between edges with data buffered.
    bus32.dec_ready_i = 1'b0;
    send32(32'h00100093, 6'b000010, 64'h1, 1'b0);
    send32(32'h00200113, 6'b000010, 64'h2, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    sb_q.delete();
    check_val("arst_dec_valid", 64'(bus32.dec_valid_o),   64'd0);
    check_val("arst_occupancy", 64'(bus32.occupancy_o),   64'd0);
    check_val("arst_ready",     64'(bus32.fetch_ready_o), 64'd0);
    check_val("arst_pc",        64'(bus32.dec_pc_o),      64'd0);
    check_val("arst_rd",        64'(bus32.rd_o),          64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    bus32.dec_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("arst_no_residue", 64'(bus32.dec_valid_o), 64'd0);
    send32(32'h002081B3, 6'b000001, 64'h0, 1'b0);
    drain();
    check_val("end_occupancy", 64'(bus32.occupancy_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
